// File: rtl/dm_store_buffer_if.sv
// Store-buffer signal bundle: pipeline store/load requests plus the data-memory port.
// The buffer connects through the slave modport; the pipeline/dm side uses master.
interface dm_store_buffer_if #(
  parameter int DEPTH = 4,
  parameter int AW    = 8,
  parameter int DW    = 32
);
  logic                     st_valid;
  logic [AW-1:0]            st_addr;
  logic [DW-1:0]            st_data;
  logic                     st_ready;
  logic                     ld_req;
  logic [AW-1:0]            ld_addr;
  logic                     ld_valid;
  logic [DW-1:0]            ld_data;
  logic [AW-1:0]            dm_addr;
  logic [DW-1:0]            dm_din;
  logic                     dm_write;
  logic                     dm_read;
  logic [DW-1:0]            dm_dout;
  logic [$clog2(DEPTH):0]   count;
  logic                     empty;

  modport slave (
    input  st_valid, st_addr, st_data, ld_req, ld_addr, dm_dout,
    output st_ready, ld_valid, ld_data, dm_addr, dm_din, dm_write, dm_read, count, empty
  );

  modport master (
    output st_valid, st_addr, st_data, ld_req, ld_addr, dm_dout,
    input  st_ready, ld_valid, ld_data, dm_addr, dm_din, dm_write, dm_read, count, empty
  );
endinterface

// File: rtl/dm_store_buffer.sv
// MEM-stage store buffer: FIFO of stores drained into dm one per cycle, loads forwarded from the
// youngest match or read from dm with a fixed 1-cycle latency; st_ready drops only when full.
module dm_store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 8,
  parameter int DW    = 32
) (
  input logic              clk,
  input logic              rst,
  dm_store_buffer_if.slave sb
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } entry_t;

  entry_t           mem_q [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ld_valid_q, ld_hit_q;
  logic [DW-1:0]    ld_fwd_q, ld_fwd_d;

  logic             push, pop, hit;
  logic [DW-1:0]    hit_data;
  logic [PW-1:0]    idx;

  assign sb.st_ready = (count_q < CW'(DEPTH));
  assign sb.empty    = (count_q == '0);
  assign sb.count    = count_q;

  assign push = sb.st_valid & sb.st_ready;
  assign pop  = ~sb.empty & ~sb.ld_req;

  // Scan oldest to youngest so the last match (nearest tail) wins.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if (vld_q[idx] && (mem_q[idx].addr == sb.ld_addr)) begin
        hit      = 1'b1;
        hit_data = mem_q[idx].data;
      end
    end
  end

  assign sb.dm_write = pop & ~rst;
  assign sb.dm_read  = sb.ld_req & ~hit & ~rst;
  assign sb.dm_addr  = sb.ld_req ? sb.ld_addr : mem_q[head_q].addr;
  assign sb.dm_din   = mem_q[head_q].data;

  always_comb begin
    head_d   = head_q;
    tail_d   = tail_q;
    vld_d    = vld_q;
    ld_fwd_d = ld_fwd_q;
    if (pop) begin
      head_d        = head_q + PW'(1);
      vld_d[head_q] = 1'b0;
    end
    if (push) begin
      tail_d        = tail_q + PW'(1);
      vld_d[tail_q] = 1'b1;
    end
    count_d = count_q + CW'(push) - CW'(pop);
    if (sb.ld_req && hit) begin
      ld_fwd_d = hit_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      vld_q      <= '0;
      ld_valid_q <= 1'b0;
      ld_hit_q   <= 1'b0;
      ld_fwd_q   <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      vld_q      <= vld_d;
      ld_valid_q <= sb.ld_req;
      ld_hit_q   <= hit;
      ld_fwd_q   <= ld_fwd_d;
    end
  end

  // Entry payload needs no reset; the valid bits gate every use of it.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem_q[tail_q] <= '{addr: sb.st_addr, data: sb.st_data};
    end
  end

  // A miss returns dm's registered read data in the cycle after the request.
  assign sb.ld_valid = ld_valid_q;
  assign sb.ld_data  = (ld_valid_q && !ld_hit_q) ? sb.dm_dout : ld_fwd_q;
endmodule

// File: tb/tb_dm_store_buffer.sv
// Bench for dm_store_buffer: directed scenarios then random traffic against a queue-based model.
module tb_dm_store_buffer;
  localparam int DEPTH = 4;
  localparam int AW    = 8;
  localparam int DW    = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dm_store_buffer_if #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) bus ();

  dm_store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .sb  (bus)
  );

  // Behavioural data memory seen by the DUT.
  logic [DW-1:0] dm_mem [256];
  always @(posedge clk) begin
    if (bus.dm_write) dm_mem[bus.dm_addr] <= bus.dm_din;
    if (bus.dm_read)  bus.dm_dout <= dm_mem[bus.dm_addr];
  end

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } st_t;

  st_t           q[$];
  logic [DW-1:0] ref_mem [256];
  logic          exp_lv;
  logic [DW-1:0] exp_ld;
  int            n_chk;
  int            n_fail;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: check last cycle's load result, apply inputs, check comb outputs, advance model.
  task automatic step(input bit sv, input logic [AW-1:0] sa, input logic [DW-1:0] sd,
                      input bit lr, input logic [AW-1:0] la);
    bit            hit;
    bit            full;
    bit            pop;
    logic [DW-1:0] hd;
    @(negedge clk);
    chk("ld_valid", bus.ld_valid, exp_lv);
    if (exp_lv) chk("ld_data", bus.ld_data, exp_ld);
    bus.st_valid = sv; bus.st_addr = sa; bus.st_data = sd;
    bus.ld_req   = lr; bus.ld_addr = la;
    #1;
    full = (q.size() >= DEPTH);
    chk("count", bus.count, q.size());
    chk("empty", bus.empty, q.size() == 0);
    chk("st_ready", bus.st_ready, !full);
    hit = 1'b0;
    hd  = '0;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (!hit && q[i].a == la) begin
        hit = 1'b1;
        hd  = q[i].d;
      end
    end
    pop = !lr && (q.size() > 0);
    chk("dm_write", bus.dm_write, pop);
    if (pop) begin
      chk("drain_addr", bus.dm_addr, q[0].a);
      chk("drain_data", bus.dm_din, q[0].d);
    end
    chk("dm_read", bus.dm_read, lr && !hit);
    if (lr && !hit) chk("read_addr", bus.dm_addr, la);
    exp_lv = lr;
    exp_ld = hit ? hd : ref_mem[la];
    if (pop) begin
      ref_mem[q[0].a] = q[0].d;
      void'(q.pop_front());
    end
    if (sv && !full) q.push_back('{a: sa, d: sd});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, '0);
  endtask

  // Reset raised mid-cycle, before the edge that would have committed a drain.
  task automatic reset_mid();
    @(negedge clk);
    chk("ld_valid_pre_rst", bus.ld_valid, exp_lv);
    bus.st_valid = 1'b0; bus.ld_req = 1'b0;
    #1;
    chk("dm_write_pre_rst", bus.dm_write, q.size() > 0);
    rst = 1'b1;
    #1;
    chk("rst_count", bus.count, 0);
    chk("rst_empty", bus.empty, 1);
    chk("rst_dm_write", bus.dm_write, 0);
    chk("rst_ld_valid", bus.ld_valid, 0);
    chk("rst_ld_data", bus.ld_data, 0);
    bus.ld_req  = 1'b1;
    bus.ld_addr = 8'h33;
    #1;
    chk("rst_dm_read", bus.dm_read, 0);
    bus.ld_req = 1'b0;
    @(negedge clk);
    chk("rst_hold_ld_valid", bus.ld_valid, 0);
    rst = 1'b0;
    q.delete();
    exp_lv = 1'b0;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    exp_lv = 1'b0;
    exp_ld = '0;
    for (int i = 0; i < 256; i++) begin
      dm_mem[i]  = '0;
      ref_mem[i] = '0;
    end
    bus.st_valid = 1'b0; bus.st_addr = '0; bus.st_data = '0;
    bus.ld_req   = 1'b0; bus.ld_addr = '0; bus.dm_dout = '0;
    rst = 1'b1;
    #1;
    chk("por_count", bus.count, 0);
    chk("por_empty", bus.empty, 1);
    chk("por_ld_valid", bus.ld_valid, 0);
    chk("por_ld_data", bus.ld_data, 0);
    @(negedge clk);
    rst = 1'b0;

    // Store then drain, then a load served from dm.
    step(1'b1, 8'h01, 32'hffaa, 1'b0, '0);
    step(1'b1, 8'h02, 32'h2333, 1'b0, '0);
    idle(3);
    chk("drained_empty", bus.empty, 1);
    step(1'b0, '0, '0, 1'b1, 8'h02);
    idle(1);
    chk("dm_load_02", bus.ld_data, 32'h2333);

    // Forwarding picks the youngest of two same-address stores.
    step(1'b1, 8'h05, 32'h1111, 1'b1, 8'h09);
    step(1'b1, 8'h05, 32'h2222, 1'b1, 8'h09);
    step(1'b0, '0, '0, 1'b1, 8'h05);
    idle(1);
    chk("fwd_youngest", bus.ld_data, 32'h2222);
    idle(3);

    // Fill while loads block the drain; a fifth store is dropped.
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h10 + i), 32'(32'hc000 + i), 1'b1, 8'h09);
    step(1'b1, 8'h14, 32'hdead, 1'b1, 8'h09);
    chk("full_count", bus.count, 4);
    step(1'b0, '0, '0, 1'b0, '0);
    step(1'b0, '0, '0, 1'b1, 8'h14);
    chk("after_drain_ready", bus.st_ready, 1);
    idle(5);

    // Streaming push+pop across the pointer wrap.
    for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h20 + i), 32'(32'h5000 + i), 1'b0, '0);
    idle(2);

    // A same-cycle store is invisible to the load; the next load forwards it.
    step(1'b1, 8'h07, 32'habcd, 1'b1, 8'h07);
    step(1'b0, '0, '0, 1'b1, 8'h07);
    idle(2);

    // Reset in the middle of draining three entries.
    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h40 + i), 32'(32'h7700 + i), 1'b1, 8'h09);
    step(1'b0, '0, '0, 1'b0, '0);
    reset_mid();
    idle(1);

    // Random traffic on a small address range to provoke hits and wrap.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), $urandom,
           ($urandom_range(0, 9) < 4), 8'($urandom_range(0, 15)));
    end
    idle(DEPTH + 1);
    for (int a = 0; a < 16; a++) step(1'b0, '0, '0, 1'b1, 8'(a));
    idle(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
